// File: rtl/pc_fetch_reg.sv
// Fetch-stage PC register with branch/flush/stall arbitration and IF/ID register.
// Optional PC_FETCH_PERF_CNT_EN adds fetch and redirect performance counters.
module pc_fetch_reg #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc,
  output logic            inst_sram_en,
  output logic [PC_W-1:0] inst_sram_addr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            if_id_adel
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     redirect_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            run_q;
  logic [PC_W-1:0] if_id_pc_q;
  logic            if_id_valid_q;
  logic            if_id_adel_q;
  logic            redirect;
  logic            aligned;

  assign aligned = (pc_q[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else if (br_taken && !stall) begin
      state_d = StIdle;
    end else if (br_taken) begin
      state_d = StPend;
    end else if (state_q == StPend && !stall) begin
      state_d = StIdle;
    end
  end

  // PC / pending-target selection in priority order
  always_comb begin
    pc_d     = pc_q;
    pend_d   = pend_q;
    redirect = 1'b0;
    if (flush) begin
      pc_d     = flush_pc;
      pend_d   = '0;
      redirect = 1'b1;
    end else if (br_taken && !stall) begin
      pc_d     = br_target;
      redirect = 1'b1;
    end else if (br_taken) begin
      pend_d = br_target;
    end else if (state_q == StPend && !stall) begin
      pc_d     = pend_q;
      redirect = 1'b1;
    end else if (!stall && run_q) begin
      // The first cycle after reset holds RESET_PC so it is actually fetched.
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_adel_q  <= 1'b0;
    end else if (flush) begin
      if_id_pc_q    <= pc_q;
      if_id_valid_q <= 1'b0;
      if_id_adel_q  <= 1'b0;
    end else if (!stall) begin
      if_id_pc_q    <= pc_q;
      if_id_valid_q <= run_q;
      if_id_adel_q  <= run_q & ~aligned;
    end
  end

  // Outputs
  always_comb begin
    pc             = pc_q;
    inst_sram_addr = pc_q;
    inst_sram_en   = ~rst & run_q & ~stall & aligned;
    if_id_pc       = if_id_pc_q;
    if_id_valid    = if_id_valid_q;
    if_id_adel     = if_id_adel_q;
  end

`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (inst_sram_en && !flush) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redirect) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed self-checking bench for pc_fetch_reg; upstream pc_next is modelled as pc + 4.
module tb_pc_fetch_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        if_id_adel;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_reg dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .pc_next       (pc_next),
    .pc            (pc),
    .inst_sram_en  (inst_sram_en),
    .inst_sram_addr(inst_sram_addr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .if_id_adel    (if_id_adel)
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .redirect_cnt  (redirect_cnt)
`endif
  );

  assign pc_next = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    flush_pc = '0; br_target = '0;
    tick(); tick();
    checks++;
    if (pc !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc got %h want BFC00000", pc); end
    checks++;
    if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", inst_sram_en); end
    checks++;
    if ({if_id_pc, if_id_valid, if_id_adel} !== 34'h0) begin
      errors++; $display("FAIL reset_ifid got %h/%b/%b want 0/0/0", if_id_pc, if_id_valid, if_id_adel);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pc !== 32'hBFC00000 || inst_sram_en !== 1'b1) begin
      errors++; $display("FAIL first_fetch got %h en %b want BFC00000 en 1", pc, inst_sram_en);
    end
    checks++;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL first_valid got %b want 0", if_id_valid); end
  endtask

  task automatic test_sequential();
    tick();
    checks++;
    if (pc !== 32'hBFC00004 || if_id_pc !== 32'hBFC00000 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL seq1 got %h/%h/%b want BFC00004/BFC00000/1", pc, if_id_pc, if_id_valid);
    end
    tick();
    checks++;
    if (pc !== 32'hBFC00008 || if_id_pc !== 32'hBFC00004 || inst_sram_addr !== 32'hBFC00008) begin
      errors++; $display("FAIL seq2 got %h/%h/%h want BFC00008/BFC00004/BFC00008",
                         pc, if_id_pc, inst_sram_addr);
    end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_target = 32'hBFC00100;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc !== 32'hBFC00100 || if_id_pc !== 32'hBFC00008 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL branch got %h/%h/%b want BFC00100/BFC00008/1", pc, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_stall_pend();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80001000;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_en got %b want 0", inst_sram_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      br_taken = 1'b0;
      checks++;
      if (pc !== 32'hBFC00100 || inst_sram_en !== 1'b0 || if_id_pc !== 32'hBFC00008) begin
        errors++; $display("FAIL stall_hold%0d got %h en %b ifid %h want BFC00100 en 0 ifid BFC00008",
                           i, pc, inst_sram_en, if_id_pc);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h80001000 || if_id_pc !== 32'hBFC00100) begin
      errors++; $display("FAIL pend_apply got %h/%h want 80001000/BFC00100", pc, if_id_pc);
    end
    tick();
    checks++;
    if (pc !== 32'h80001004) begin errors++; $display("FAIL pend_idle got %h want 80001004", pc); end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80002000;
    tick();
    br_taken = 1'b0;
    tick();
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h80003000;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc !== 32'h80003000) begin errors++; $display("FAIL br_over_pend got %h want 80003000", pc); end
    tick();
    checks++;
    if (pc !== 32'h80003004) begin errors++; $display("FAIL br_over_pend_next got %h want 80003004", pc); end
  endtask

  task automatic test_flush();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80004000;
    flush = 1'b1; flush_pc = 32'hBFC00380;
    tick();
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    checks++;
    if (pc !== 32'hBFC00380 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL flush got %h valid %b want BFC00380 valid 0", pc, if_id_valid);
    end
    tick();
    checks++;
    if (pc !== 32'hBFC00384 || if_id_pc !== 32'hBFC00380 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL flush_clr got %h/%h/%b want BFC00384/BFC00380/1", pc, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_misaligned();
    br_taken = 1'b1; br_target = 32'hBFC00102;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc !== 32'hBFC00102 || inst_sram_en !== 1'b0) begin
      errors++; $display("FAIL misalign got %h en %b want BFC00102 en 0", pc, inst_sram_en);
    end
    tick();
    checks++;
    if (if_id_adel !== 1'b1 || if_id_pc !== 32'hBFC00102 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL adel got %b/%h/%b want 1/BFC00102/1", if_id_adel, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hFFFFFFFC;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc !== 32'hFFFFFFFC || inst_sram_en !== 1'b1) begin
      errors++; $display("FAIL wrap_pre got %h en %b want FFFFFFFC en 1", pc, inst_sram_en);
    end
    tick();
    checks++;
    if (pc !== 32'h00000000 || if_id_pc !== 32'hFFFFFFFC || if_id_adel !== 1'b0) begin
      errors++; $display("FAIL wrap got %h/%h/%b want 00000000/FFFFFFFC/0", pc, if_id_pc, if_id_adel);
    end
  endtask

  task automatic test_reset_in_pend();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80005000;
    tick();
    br_taken = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (pc !== 32'hBFC00000 || inst_sram_en !== 1'b0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL rst_pend got %h en %b v %b want BFC00000 en 0 v 0", pc, inst_sram_en,
                         if_id_valid);
    end
    rst = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'hBFC00000) begin errors++; $display("FAIL rst_pend_clr got %h want BFC00000", pc); end
    tick();
    checks++;
    if (pc !== 32'hBFC00004) begin errors++; $display("FAIL rst_pend_run got %h want BFC00004", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_pend();
    test_back_to_back();
    test_flush();
    test_misaligned();
    test_wrap();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_reg.md
Name: pc_fetch_reg

Overview:
- Fetch-stage PC register: the sequential owner of the fetch PC, consuming the pc+4 value from the next-PC logic.
- Arbitrates among sequential advance, branch redirect, exception flush and pipeline stall.
- Drives the instruction SRAM request and the IF/ID pipeline register (PC, valid, address-error flag).
- A pending-redirect latch holds a branch target that arrives during a stall, so redirects are never lost.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded by reset.
- PC_W, 32, PC / address width (fixed at 32 for MIPS32).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- stall  input  1  hold fetch PC and IF/ID register this cycle
- flush  input  1  exception/eret flush; redirect to flush_pc
- flush_pc  input  32  exception vector or EPC
- br_taken  input  1  branch/jump resolved taken in ID
- br_target  input  32  branch/jump target
- pc_next  input  32  sequential next PC (pc+4) from next-PC logic
- pc  output  32  current fetch PC
- inst_sram_en  output  1  instruction SRAM read enable
- inst_sram_addr  output  32  instruction SRAM address (= pc)
- if_id_pc  output  32  PC of the instruction presented to ID
- if_id_valid  output  1  IF/ID entry holds a real instruction
- if_id_adel  output  1  fetch address misaligned (AdEL) for if_id_pc

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; if_id_pc=0, if_id_valid=0, if_id_adel=0.
  - FSM=IDLE; pending_target=0; internal run flag=0.
  - inst_sram_en=0 while rst high.
  - Reset mid-operation overrides every other input, including a pending redirect.
- Run flag: set on the first cycle after rst deasserts; gates inst_sram_en and if_id_valid.
- inst_sram_en = run & ~stall & (pc[1:0]==0), combinational. inst_sram_addr = pc, combinational.
- SRAM read latency is 1 cycle. The instruction fetched at pc is sampled by ID alongside if_id_pc.
- PC update priority, per posedge (rst excluded):
  1. flush: pc<=flush_pc; FSM->IDLE; pending cleared. Ignores stall.
  2. br_taken & ~stall: pc<=br_target. FSM->IDLE; this also overrides any pending target.
  3. br_taken & stall: pc holds; pending_target<=br_target; FSM->PEND.
  4. FSM==PEND & ~stall: pc<=pending_target; FSM->IDLE.
  5. stall: pc holds.
  6. otherwise: pc<=pc_next.
- FSM states:
  - IDLE: no redirect owed.
  - PEND: redirect owed.
  - A later br_taken while in PEND and stalled overwrites pending_target (newest wins).
- Delay slot: br_taken is resolved while the delay slot occupies IF. The delay slot is therefore not squashed by br_taken; it advances to ID normally.
- IF/ID register:
  - flush: if_id_valid<=0, if_id_adel<=0; if_id_pc<=pc.
  - ~stall: if_id_pc<=pc; if_id_valid<=run; if_id_adel<=run & (pc[1:0]!=0).
  - stall & ~flush: all IF/ID fields hold.
- Arithmetic: the block does no addition; pc_next wraps modulo 2^32 upstream (0xFFFFFFFC -> 0x00000000) and is loaded verbatim.
- Misaligned targets are loaded unchanged. No SRAM request is made for a misaligned pc; the AdEL flag travels with the entry.
- Simultaneous cases:
  - flush & br_taken: flush wins.
  - flush & stall: flush wins.
  - br_taken in the same cycle stall drops while in PEND: br_target wins over pending_target.

Optional Feature:
- Macro: PC_FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt[31:0], reset to 0.
  - Increments by 1 on each posedge where inst_sram_en=1 and flush=0; wraps at 2^32.
  - Adds output redirect_cnt[31:0], reset to 0, incremented once for each applied flush or branch redirect (cases 1, 2, 4). A latch into PEND (case 3) is not counted.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then release with no stall/branch -> cycle 1 pc=BFC00000, inst_sram_en=1. Next cycles pc=BFC00004, BFC00008; if_id_pc lags pc by one cycle; if_id_valid=1 from the second cycle after release.
- br_taken=1, br_target=BFC00100, stall=0 at pc=BFC00008 -> next pc=BFC00100; if_id_pc=BFC00008 (delay slot) with valid=1.
- stall=1 for 3 cycles, br_taken pulsed in the 1st stalled cycle with target 80001000 -> pc held and inst_sram_en=0 throughout; FSM=PEND; on the first unstalled cycle pc<=80001000, FSM=IDLE.
- flush=1, flush_pc=BFC00380 together with stall=1 and br_taken=1 -> pc=BFC00380; if_id_valid=0 next cycle; pending cleared.
- br_target=BFC00102 -> pc=BFC00102, inst_sram_en=0; next cycle if_id_adel=1, if_id_pc=BFC00102.
- pc_next driven to 00000000 with pc=FFFFFFFC -> pc=00000000. Separately, rst asserted while in PEND -> pc=BFC00000, FSM=IDLE.
